cpu_l1_cache: RTL and testbench

- Direct-mapped, write-through, no-write-allocate cache between the B322 CPU memory port and the main memory/bus unit.
- Consumes the CPU's address/data/we/start request and returns q/busy.
- Cached region is forwarded to the memory side only on misses and writes.
- Addresses at or above CACHE_LIMIT (I/O, ROM, VRAM) always bypass the cache, uncached, one access at a time.

---
 rtl/cpu_l1_cache_if.sv | 23 ++
 rtl/cpu_l1_cache.sv | 196 +++++++++++++++++++
 tb/tb_cpu_l1_cache.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_l1_cache_if.sv
// Request/response bus used on both sides of the L1 cache.
// A requester (master) drives addr/data/we with a one-cycle start pulse and
// watches busy; the responder (slave) returns q and busy.
//   addr  : word address
//   data  : write data
//   we    : 1 = write, 0 = read
//   start : one-cycle request pulse
//   q     : read data
//   busy  : request in progress
interface cpu_l1_cache_if #(
  parameter int unsigned AddrWidth = 27,
  parameter int unsigned DataWidth = 32
);
  logic [AddrWidth-1:0] addr;
  logic [DataWidth-1:0] data;
  logic                 we;
  logic                 start;
  logic [DataWidth-1:0] q;
  logic                 busy;

  modport master (output addr, output data, output we, output start, input q, input busy);
  modport slave  (input addr, input data, input we, input start, output q, output busy);
endinterface

// File: rtl/cpu_l1_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 cache with one 32-bit
// word per line. Addresses at or above CACHE_LIMIT bypass the cache entirely.
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset
//   flush : one-cycle pulse, invalidates every line
//   cpu   : slave side of the CPU request bus (addr/data/we/start in, q/busy out)
//   mem   : master side of the memory bus (addr/data/we/start out, q/busy in)
module cpu_l1_cache #(
  parameter int unsigned INDEX_BITS  = 8,
  parameter logic [26:0] CACHE_LIMIT = 27'h0800000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  cpu_l1_cache_if.slave  cpu,
  cpu_l1_cache_if.master mem
);

  localparam int unsigned Lines   = 1 << INDEX_BITS;
  localparam int unsigned TagBits = 27 - INDEX_BITS;

  typedef enum logic [2:0] {StIdle, StLookup, StMemReq, StMemWait, StDone} state_e;

  state_e              state_q, state_d;
  logic [26:0]         addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic                we_q, we_d;
  logic                busy_q, busy_d;
  logic [31:0]         cpu_q_q, cpu_q_d;
  logic                mem_start_q, mem_start_d;
  logic [26:0]         mem_addr_q, mem_addr_d;
  logic [31:0]         mem_data_q, mem_data_d;
  logic                mem_we_q, mem_we_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                wait_first_q, wait_first_d;
  logic                flush_pend_q, flush_pend_d;
  logic [Lines-1:0]    valid_q, valid_d;

  logic [TagBits-1:0]  tag_mem  [Lines];
  logic [31:0]         line_mem [Lines];

  logic [INDEX_BITS-1:0] idx;
  logic [TagBits-1:0]    tag;
  logic                  cacheable;
  logic                  hit;
  logic                  line_we;
  logic [31:0]           line_wdata;
  logic                  clear_all;

  assign idx       = addr_q[INDEX_BITS-1:0];
  assign tag       = addr_q[26:INDEX_BITS];
  assign cacheable = (addr_q < CACHE_LIMIT);
  assign hit       = valid_q[idx] && (tag_mem[idx] == tag);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    we_d         = we_q;
    busy_d       = busy_q;
    cpu_q_d      = cpu_q_q;
    mem_start_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_we_d     = mem_we_q;
    rdata_d      = rdata_q;
    wait_first_d = wait_first_q;
    flush_pend_d = flush_pend_q;
    valid_d      = valid_q;
    line_we      = 1'b0;
    line_wdata   = data_q;
    clear_all    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (flush) clear_all = 1'b1;
        if (cpu.start) begin
          addr_d  = cpu.addr;
          data_d  = cpu.data;
          we_d    = cpu.we;
          busy_d  = 1'b1;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (!we_q && cacheable && hit) begin
          cpu_q_d = line_mem[idx];
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          // mem_start_q is high exactly while in StMemReq.
          mem_start_d = 1'b1;
          mem_addr_d  = addr_q;
          mem_data_d  = data_q;
          mem_we_d    = we_q;
          state_d     = StMemReq;
        end
      end
      StMemReq: begin
        wait_first_d = 1'b1;
        state_d      = StMemWait;
      end
      StMemWait: begin
        // Memory may not have raised busy yet in the first cycle after start.
        if (wait_first_q) begin
          wait_first_d = 1'b0;
        end else if (!mem.busy) begin
          rdata_d = mem.q;
          state_d = StDone;
        end
      end
      StDone: begin
        if (!we_q) cpu_q_d = rdata_q;
        if (cacheable) begin
          if (!we_q) begin
            line_we    = 1'b1;
            line_wdata = rdata_q;
          end else if (hit) begin
            line_we    = 1'b1;
            line_wdata = data_q;
          end
        end
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Flush seen outside idle waits for the return to idle and wins over a fill.
    if (state_q != StIdle) begin
      flush_pend_d = flush_pend_q | flush;
      if (state_d == StIdle && (flush_pend_q || flush)) begin
        clear_all    = 1'b1;
        flush_pend_d = 1'b0;
        line_we      = 1'b0;
      end
    end

    if (clear_all) begin
      valid_d = '0;
    end else if (line_we) begin
      valid_d[idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      data_q       <= '0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      cpu_q_q      <= '0;
      mem_start_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_we_q     <= 1'b0;
      rdata_q      <= '0;
      wait_first_q <= 1'b0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      we_q         <= we_d;
      busy_q       <= busy_d;
      cpu_q_q      <= cpu_q_d;
      mem_start_q  <= mem_start_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_we_q     <= mem_we_d;
      rdata_q      <= rdata_d;
      wait_first_q <= wait_first_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
    end
  end

  // Tag/data arrays carry no reset; validity is tracked by valid_q alone.
  always_ff @(posedge clk) begin
    if (line_we && !reset) begin
      tag_mem[idx]  <= tag;
      line_mem[idx] <= line_wdata;
    end
  end

  assign cpu.q     = cpu_q_q;
  assign cpu.busy  = busy_q;
  assign mem.addr  = mem_addr_q;
  assign mem.data  = mem_data_q;
  assign mem.we    = mem_we_q;
  assign mem.start = mem_start_q;

endmodule

// File: tb/tb_cpu_l1_cache.sv
module tb_cpu_l1_cache;
  logic clk = 1'b0;
  logic reset;
  logic flush;

  always #5 clk = ~clk;

  cpu_l1_cache_if cpu_bus ();
  cpu_l1_cache_if mem_bus ();

  cpu_l1_cache dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .cpu   (cpu_bus),
    .mem   (mem_bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Memory responder: on a start pulse, stays busy for mem_lat negedges.
  int unsigned mem_lat   = 3;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_busy_r = 1'b0;
  logic [31:0] mem_q_r    = 32'h0;
  int          mem_cnt    = 0;
  int          mem_starts = 0;
  logic [26:0] last_addr  = '0;
  logic [31:0] last_data  = '0;
  logic        last_we    = 1'b0;

  assign mem_bus.busy = mem_busy_r;
  assign mem_bus.q    = mem_q_r;

  always @(negedge clk) begin
    if (reset) begin
      mem_busy_r = 1'b0;
      mem_cnt    = 0;
    end else if (mem_bus.start) begin
      mem_starts++;
      last_addr  = mem_bus.addr;
      last_data  = mem_bus.data;
      last_we    = mem_bus.we;
      mem_q_r    = mem_rdata;
      mem_cnt    = int'(mem_lat);
      mem_busy_r = (mem_lat != 0);
    end else if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) mem_busy_r = 1'b0;
    end
  end

  // One CPU request; returns q at busy fall, busy cycles and mem_start count.
  task automatic do_req(input logic [26:0] a, input logic w, input logic [31:0] d,
                        input logic fl, output logic [31:0] q, output int cyc,
                        output int starts);
    int s0;
    s0 = mem_starts;
    @(negedge clk);
    cpu_bus.addr  = a;
    cpu_bus.data  = d;
    cpu_bus.we    = w;
    cpu_bus.start = 1'b1;
    flush         = fl;
    @(negedge clk);
    cpu_bus.start = 1'b0;
    flush         = 1'b0;
    cyc = 0;
    while (cpu_bus.busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 200) begin
      miscompares++;
      $display("FAIL timeout addr=%h: busy never fell", a);
    end
    vectors++;
    q = cpu_bus.q;
    starts = mem_starts - s0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush = 1'b0;
    cpu_bus.start = 1'b0;
    cpu_bus.addr  = '0;
    cpu_bus.data  = '0;
    cpu_bus.we    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    if (cpu_bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", cpu_bus.busy); end
    vectors++;
    if (cpu_bus.q !== 32'h0) begin miscompares++; $display("FAIL reset_q got %h want 0", cpu_bus.q); end
    vectors++;
    if (mem_bus.start !== 1'b0) begin miscompares++; $display("FAIL reset_mstart got %b want 0", mem_bus.start); end
    vectors++;
    if (mem_bus.we !== 1'b0) begin miscompares++; $display("FAIL reset_mwe got %b want 0", mem_bus.we); end
    vectors++;
    if (mem_bus.addr !== 27'h0) begin miscompares++; $display("FAIL reset_maddr got %h want 0", mem_bus.addr); end
    vectors++;
    if (mem_bus.data !== 32'h0) begin miscompares++; $display("FAIL reset_mdata got %h want 0", mem_bus.data); end
    vectors++;
  endtask

  task automatic test_read_miss_hit();
    logic [31:0] q; int cyc; int st;
    mem_lat = 3; mem_rdata = 32'hDEADBEEF;
    do_req(27'h000010, 1'b0, 32'h0, 1'b0, q, cyc, st);
    if (st !== 1) begin miscompares++; $display("FAIL miss_starts got %0d want 1", st); end
    vectors++;
    if (last_we !== 1'b0 || last_addr !== 27'h000010) begin
      miscompares++; $display("FAIL miss_req got we=%b addr=%h want we=0 addr=000010", last_we, last_addr);
    end
    vectors++;
    if (q !== 32'hDEADBEEF) begin miscompares++; $display("FAIL miss_q got %h want deadbeef", q); end
    vectors++;
    mem_rdata = 32'hBAD0BAD0;
    do_req(27'h000010, 1'b0, 32'h0, 1'b0, q, cyc, st);
    if (st !== 0) begin miscompares++; $display("FAIL hit_starts got %0d want 0", st); end
    vectors++;
    if (cyc !== 1) begin miscompares++; $display("FAIL hit_busy_cycles got %0d want 1", cyc); end
    vectors++;
    if (q !== 32'hDEADBEEF) begin miscompares++; $display("FAIL hit_q got %h want deadbeef", q); end
    vectors++;
  endtask

  task automatic test_write_through();
    logic [31:0] q; int cyc; int st;
    mem_rdata = 32'hBAD0BAD0;
    do_req(27'h000010, 1'b1, 32'h12345678, 1'b0, q, cyc, st);
    if (st !== 1) begin miscompares++; $display("FAIL wr_starts got %0d want 1", st); end
    vectors++;
    if (last_we !== 1'b1 || last_data !== 32'h12345678 || last_addr !== 27'h000010) begin
      miscompares++;
      $display("FAIL wr_req got we=%b data=%h addr=%h want we=1 data=12345678 addr=000010",
               last_we, last_data, last_addr);
    end
    vectors++;
    do_req(27'h000010, 1'b0, 32'h0, 1'b0, q, cyc, st);
    if (st !== 0) begin miscompares++; $display("FAIL wr_hit_starts got %0d want 0", st); end
    vectors++;
    if (q !== 32'h12345678) begin miscompares++; $display("FAIL wr_hit_q got %h want 12345678", q); end
    vectors++;
  endtask

  task automatic test_alias();
    logic [31:0] q; int cyc; int st;
    mem_rdata = 32'hA1A1A1A1;
    do_req(27'h000110, 1'b0, 32'h0, 1'b0, q, cyc, st);
    if (st !== 1 || q !== 32'hA1A1A1A1) begin
      miscompares++; $display("FAIL alias_fill got starts=%0d q=%h want 1 a1a1a1a1", st, q);
    end
    vectors++;
    mem_rdata = 32'h55555555;
    do_req(27'h000010, 1'b0, 32'h0, 1'b0, q, cyc, st);
    if (st !== 1 || q !== 32'h55555555) begin
      miscompares++; $display("FAIL alias_evict got starts=%0d q=%h want 1 55555555", st, q);
    end
    vectors++;
  endtask

  task automatic test_bypass();
    logic [31:0] q; int cyc; int st; int tot;
    mem_rdata = 32'h11111111;
    do_req(27'h0800000, 1'b0, 32'h0, 1'b0, q, cyc, st);
    tot = st;
    mem_rdata = 32'h22222222;
    do_req(27'h0800000, 1'b0, 32'h0, 1'b0, q, cyc, st);
    tot += st;
    if (tot !== 2) begin miscompares++; $display("FAIL bypass_starts got %0d want 2", tot); end
    vectors++;
    if (q !== 32'h22222222) begin miscompares++; $display("FAIL bypass_q got %h want 22222222", q); end
    vectors++;
    mem_rdata = 32'h33333333;
    do_req(27'h07FFFFF, 1'b0, 32'h0, 1'b0, q, cyc, st);
    tot = st;
    mem_rdata = 32'h44444444;
    do_req(27'h07FFFFF, 1'b0, 32'h0, 1'b0, q, cyc, st);
    tot += st;
    if (tot !== 1) begin miscompares++; $display("FAIL limit_starts got %0d want 1", tot); end
    vectors++;
    if (q !== 32'h33333333) begin miscompares++; $display("FAIL limit_q got %h want 33333333", q); end
    vectors++;
  endtask

  task automatic test_flush_wait();
    logic [31:0] q; int cyc; int st; int n;
    mem_lat = 4; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    cpu_bus.addr = 27'h000020; cpu_bus.we = 1'b0; cpu_bus.start = 1'b1;
    @(negedge clk);
    cpu_bus.start = 1'b0;
    n = 0;
    while (mem_bus.start !== 1'b1 && n < 50) begin n++; @(negedge clk); end
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n = 0;
    while (cpu_bus.busy === 1'b1 && n < 200) begin n++; @(negedge clk); end
    if (cpu_bus.q !== 32'hCAFEF00D) begin
      miscompares++; $display("FAIL flush_wait_q got %h want cafef00d", cpu_bus.q);
    end
    vectors++;
    mem_rdata = 32'h0F0F0F0F;
    do_req(27'h000020, 1'b0, 32'h0, 1'b0, q, cyc, st);
    if (st !== 1) begin miscompares++; $display("FAIL flush_wait_refetch got %0d want 1", st); end
    vectors++;
  endtask

  task automatic test_flush_idle();
    logic [31:0] q; int cyc; int st;
    mem_lat = 2; mem_rdata = 32'h30303030;
    do_req(27'h000030, 1'b0, 32'h0, 1'b0, q, cyc, st);
    do_req(27'h000030, 1'b0, 32'h0, 1'b1, q, cyc, st);
    if (st !== 1) begin miscompares++; $display("FAIL flush_with_start got %0d want 1", st); end
    vectors++;
    do_req(27'h000030, 1'b0, 32'h0, 1'b0, q, cyc, st);
    if (st !== 0) begin miscompares++; $display("FAIL refill_hit got %0d want 0", st); end
    vectors++;
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    do_req(27'h000030, 1'b0, 32'h0, 1'b0, q, cyc, st);
    if (st !== 1) begin miscompares++; $display("FAIL flush_idle got %0d want 1", st); end
    vectors++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] q; int cyc; int st; int n;
    mem_lat = 2; mem_rdata = 32'h10101010;
    do_req(27'h000010, 1'b0, 32'h0, 1'b0, q, cyc, st);
    do_req(27'h000010, 1'b0, 32'h0, 1'b0, q, cyc, st);
    if (st !== 0) begin miscompares++; $display("FAIL pre_reset_hit got %0d want 0", st); end
    vectors++;
    mem_lat = 10;
    @(negedge clk);
    cpu_bus.addr = 27'h000040; cpu_bus.we = 1'b0; cpu_bus.start = 1'b1;
    @(negedge clk);
    cpu_bus.start = 1'b0;
    n = 0;
    while (mem_bus.start !== 1'b1 && n < 50) begin n++; @(negedge clk); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    if (cpu_bus.busy !== 1'b0 || mem_bus.start !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid got busy=%b mstart=%b want 0 0", cpu_bus.busy, mem_bus.start);
    end
    vectors++;
    mem_lat = 3; mem_rdata = 32'h77777777;
    do_req(27'h000010, 1'b0, 32'h0, 1'b0, q, cyc, st);
    if (st !== 1 || q !== 32'h77777777) begin
      miscompares++; $display("FAIL reset_mid_miss got starts=%0d q=%h want 1 77777777", st, q);
    end
    vectors++;
  endtask

  initial begin
    test_reset();
    test_read_miss_hit();
    test_write_through();
    test_alias();
    test_bypass();
    test_flush_wait();
    test_flush_idle();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
